// File: rtl/eth_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_pkg
// Description : Shared types and constants for the MII receive / FCS checker:
//               FSM state encoding, CRC-32 constants, preamble/SFD nibbles and
//               the nibble-wide CRC-32 next-state function.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;

    // MSB-first CRC-32 step over one MII nibble. The nibble is bit-reversed so
    // that wire bit 0 (first on the wire) is the first bit shifted in.
    function automatic logic [31:0] crc32_nib_next(input logic [31:0] crc,
                                                   input logic [3:0]  nib);
        logic [31:0] c;
        logic [3:0]  d;
        c = crc;
        d = {nib[0], nib[1], nib[2], nib[3]};
        for (int i = 3; i >= 0; i--) begin
            if (c[31] ^ d[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_mii_rx_fcs_crc.sv
`default_nettype none
// ============================================================================
// Module      : eth_crc32_nib
// Description : Registered nibble-wide CRC-32 (poly 0x04C11DB7, MSB-first,
//               bit-reversed nibble input, no final inversion). i_clr loads
//               the init value and has priority over i_en.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_crc32_nib
    import eth_rx_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [3:0]  i_nib,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    // CRC register: clear to init, or advance by one nibble when enabled
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_crc <= CRC32_INIT;
        end else if (i_clr) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= crc32_nib_next(r_crc, i_nib);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/eth_mii_rx_fcs.sv
`default_nettype none
// ============================================================================
// Module      : eth_mii_rx_fcs
// Description : MII receive front end. Registers the MII RX pins, detects
//               preamble/SFD, assembles bytes low-nibble first, runs CRC-32
//               over the frame including FCS and reports status at end of
//               frame.
//               Optional feature macro: RX_FCS_STRIP_EN - when defined, a
//               4-byte delay line withholds the FCS bytes from rx_byte and
//               rx_len excludes them.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mii_rx_fcs
    import eth_rx_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             mii_rx_dv,
    input  logic             mii_rx_er,
    input  logic [3:0]       mii_rxd,
    output logic [7:0]       rx_byte,
    output logic             rx_byte_vld,
    output logic             rx_sof,
    output logic             rx_done,
    output logic             rx_crc_ok,
    output logic             rx_err_align,
    output logic             rx_err_phy,
    output logic [LEN_W-1:0] rx_len
);

    localparam logic [LEN_W-1:0] c_LEN_MAX   = '1;
    localparam logic [LEN_W-1:0] c_FCS_BYTES = LEN_W'(4);

    // Input register stage
    logic             r_dv;
    logic             r_er;
    logic [3:0]       r_rxd;
    logic             r_smp;      // in-regs hold a real sample (not reset value)
    logic             r_armed;    // dv=0 seen since reset; blocks mid-frame restart

    // FSM
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic             w_sfd;
    logic             w_data_nib;
    logic             w_frame_end;

    // Assembly / status
    logic             r_phase;    // 0: expecting low nibble, 1: expecting high nibble
    logic [3:0]       r_lo_nib;
    logic [7:0]       r_asm_byte;
    logic             r_asm_vld;
    logic [LEN_W-1:0] r_byte_cnt;
    logic             r_phy_err;
    logic             r_done_pend;
    logic             r_sof_pend;
    logic [31:0]      w_crc;
    logic [LEN_W-1:0] w_len;
    logic             w_crc_match;
    logic             w_min_len;

`ifdef RX_FCS_STRIP_EN
    localparam logic [2:0] c_DL_DEPTH = 3'd4;
    logic [3:0][7:0]  r_dl;
    logic [2:0]       r_fill;
`endif

    // Register the MII pins once; everything downstream uses these copies
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_dv    <= 1'b0;
            r_er    <= 1'b0;
            r_rxd   <= 4'h0;
            r_smp   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_dv  <= mii_rx_dv;
            r_er  <= mii_rx_er;
            r_rxd <= mii_rxd;
            r_smp <= 1'b1;
            if (r_smp && !r_dv) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-nibble control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_sfd       = 1'b0;
        w_data_nib  = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_dv) begin
                    if (r_armed && (r_rxd == PREAMBLE_NIB)) begin
                        w_state_nxt = ST_PREAMBLE;
                    end else begin
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!r_dv) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_rxd == SFD_NIB) begin
                    w_state_nxt = ST_DATA;
                    w_sfd       = 1'b1;
                end else if (r_rxd != PREAMBLE_NIB) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!r_dv) begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end else begin
                    w_data_nib  = 1'b1;
                end
            end
            ST_DROP: begin
                if (!r_dv) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Nibble pairing into bytes, saturating byte count and PHY error capture
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_phase     <= 1'b0;
            r_lo_nib    <= 4'h0;
            r_asm_byte  <= 8'h00;
            r_asm_vld   <= 1'b0;
            r_byte_cnt  <= '0;
            r_phy_err   <= 1'b0;
            r_done_pend <= 1'b0;
        end else begin
            r_asm_vld   <= 1'b0;
            r_done_pend <= w_frame_end;
            if (w_sfd) begin
                r_phase    <= 1'b0;
                r_byte_cnt <= '0;
                r_phy_err  <= 1'b0;
            end else if (w_data_nib) begin
                r_phase <= ~r_phase;
                if (r_er) begin
                    r_phy_err <= 1'b1;
                end
                if (!r_phase) begin
                    r_lo_nib <= r_rxd;
                end else begin
                    r_asm_byte <= {r_rxd, r_lo_nib};
                    r_asm_vld  <= 1'b1;
                    if (r_byte_cnt != c_LEN_MAX) begin
                        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
                    end
                end
            end
        end
    end

    eth_crc32_nib u_crc (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .i_clr   (w_sfd),
        .i_en    (w_data_nib),
        .i_nib   (r_rxd),
        .o_crc   (w_crc)
    );

    assign w_crc_match = (w_crc == CRC32_RESIDUE);
    assign w_min_len   = (r_byte_cnt >= c_FCS_BYTES);

`ifdef RX_FCS_STRIP_EN
    assign w_len = w_min_len ? (r_byte_cnt - c_FCS_BYTES) : '0;
`else
    assign w_len = r_byte_cnt;
`endif

    // Output stage: byte delivery (through the FCS delay line when stripping)
    // and end-of-frame status, which is only non-zero while rx_done is high
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_byte      <= 8'h00;
            rx_byte_vld  <= 1'b0;
            rx_sof       <= 1'b0;
            rx_done      <= 1'b0;
            rx_crc_ok    <= 1'b0;
            rx_err_align <= 1'b0;
            rx_err_phy   <= 1'b0;
            rx_len       <= '0;
            r_sof_pend   <= 1'b0;
`ifdef RX_FCS_STRIP_EN
            r_dl         <= '0;
            r_fill       <= 3'd0;
`endif
        end else begin
            rx_byte_vld <= 1'b0;
            rx_sof      <= 1'b0;
            if (r_asm_vld) begin
`ifdef RX_FCS_STRIP_EN
                // The oldest byte leaves only once four newer bytes exist,
                // so the final four (the FCS) never reach rx_byte.
                r_dl <= {r_dl[2:0], r_asm_byte};
                if (r_fill == c_DL_DEPTH) begin
                    rx_byte     <= r_dl[3];
                    rx_byte_vld <= 1'b1;
                    rx_sof      <= r_sof_pend;
                    r_sof_pend  <= 1'b0;
                end else begin
                    r_fill <= r_fill + 3'd1;
                end
`else
                rx_byte     <= r_asm_byte;
                rx_byte_vld <= 1'b1;
                rx_sof      <= r_sof_pend;
                r_sof_pend  <= 1'b0;
`endif
            end
            if (w_sfd) begin
                r_sof_pend <= 1'b1;
`ifdef RX_FCS_STRIP_EN
                r_fill     <= 3'd0;
`endif
            end
            rx_done      <= r_done_pend;
            rx_crc_ok    <= r_done_pend & w_crc_match & ~r_phase & w_min_len & ~r_phy_err;
            rx_err_align <= r_done_pend & r_phase;
            rx_err_phy   <= r_done_pend & r_phy_err;
            rx_len       <= r_done_pend ? w_len : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_mii_rx_fcs.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_mii_rx_fcs
// Description : Scoreboard bench for eth_mii_rx_fcs. The driver pushes the
//               expected bytes and end-of-frame status of each frame into
//               queues; a negedge monitor pops and compares whenever the DUT
//               strobes rx_byte_vld or rx_done. Honours RX_FCS_STRIP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_mii_rx_fcs;

    localparam int LEN_W = 11;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             mii_rx_dv = 1'b0;
    logic             mii_rx_er = 1'b0;
    logic [3:0]       mii_rxd = 4'h0;
    logic [7:0]       rx_byte;
    logic             rx_byte_vld;
    logic             rx_sof;
    logic             rx_done;
    logic             rx_crc_ok;
    logic             rx_err_align;
    logic             rx_err_phy;
    logic [LEN_W-1:0] rx_len;

    eth_mii_rx_fcs #(.LEN_W(LEN_W)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .mii_rx_dv    (mii_rx_dv),
        .mii_rx_er    (mii_rx_er),
        .mii_rxd      (mii_rxd),
        .rx_byte      (rx_byte),
        .rx_byte_vld  (rx_byte_vld),
        .rx_sof       (rx_sof),
        .rx_done      (rx_done),
        .rx_crc_ok    (rx_crc_ok),
        .rx_err_align (rx_err_align),
        .rx_err_phy   (rx_err_phy),
        .rx_len       (rx_len)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0] b;
        logic       sof;
        logic [7:0] id;
    } exp_byte_t;

    typedef struct packed {
        logic             crc_ok;
        logic             align;
        logic             phy;
        logic [LEN_W-1:0] len;
        logic [7:0]       id;
    } exp_done_t;

    exp_byte_t  exp_b[$];
    exp_done_t  exp_d[$];
    logic [7:0] frm[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cur_id = 0;

    // Reference FCS: reflected CRC-32 (0xEDB88320), LSB first, final inversion
    function automatic logic [31:0] calc_fcs(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build_good();
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < 60; i++) frm.push_back(8'(i));
        f = calc_fcs(60);
        frm.push_back(f[7:0]);
        frm.push_back(f[15:8]);
        frm.push_back(f[23:16]);
        frm.push_back(f[31:24]);
    endtask

    task automatic push_expect(input logic ok, input logic align, input logic phy);
        int n_out;
`ifdef RX_FCS_STRIP_EN
        n_out = (frm.size() >= 4) ? frm.size() - 4 : 0;
`else
        n_out = frm.size();
`endif
        cur_id++;
        for (int i = 0; i < n_out; i++)
            exp_b.push_back('{b: frm[i], sof: (i == 0), id: 8'(cur_id)});
        exp_d.push_back('{crc_ok: ok, align: align, phy: phy, len: LEN_W'(n_out), id: 8'(cur_id)});
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic dv, input logic er, input logic [3:0] nib);
        @(posedge sys_clk);
        #1;
        mii_rx_dv = dv;
        mii_rx_er = er;
        mii_rxd   = nib;
    endtask

    task automatic send_frame(input int extra_nib, input int er_nib, input int gap, input bit bad_pre);
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, (bad_pre && i == 2) ? 4'hA : 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b1, (2 * i == er_nib), frm[i][3:0]);
            drive(1'b1, (2 * i + 1 == er_nib), frm[i][7:4]);
        end
        if (extra_nib >= 0) drive(1'b1, 1'b0, extra_nib[3:0]);
        repeat (gap) drive(1'b0, 1'b0, 4'h0);
    endtask

    // Monitor: pop and compare on every byte strobe and end-of-frame strobe
    exp_byte_t eb;
    exp_done_t ed;
    always @(negedge sys_clk) begin
        if (rx_byte_vld) begin
            n_chk++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL byte_unexpected: got %h sof=%b, required no byte", rx_byte, rx_sof);
            end else begin
                eb = exp_b.pop_front();
                if (rx_byte !== eb.b || rx_sof !== eb.sof) begin
                    n_fail++;
                    $display("FAIL byte_f%0d: got %h sof=%b, required %h sof=%b",
                             eb.id, rx_byte, rx_sof, eb.b, eb.sof);
                end
            end
        end
        if (rx_done) begin
            n_chk++;
            if (exp_d.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got ok=%b align=%b phy=%b len=%0d, required no done",
                         rx_crc_ok, rx_err_align, rx_err_phy, rx_len);
            end else begin
                ed = exp_d.pop_front();
                if ({rx_crc_ok, rx_err_align, rx_err_phy, rx_len} !== {ed.crc_ok, ed.align, ed.phy, ed.len}) begin
                    n_fail++;
                    $display("FAIL done_f%0d: got ok=%b align=%b phy=%b len=%0d, required ok=%b align=%b phy=%b len=%0d",
                             ed.id, rx_crc_ok, rx_err_align, rx_err_phy, rx_len,
                             ed.crc_ok, ed.align, ed.phy, ed.len);
                end else if (exp_b.size() != 0 && exp_b[0].id == ed.id) begin
                    n_fail++;
                    $display("FAIL done_early_f%0d: got done with bytes pending, required done after last byte", ed.id);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_keep;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_state", 64'({rx_byte, rx_byte_vld, rx_sof, rx_done, rx_crc_ok,
                                rx_err_align, rx_err_phy, rx_len}), 64'h0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 4'h0);

        // Good frame, then back-to-back variants with a single idle cycle
        build_good(); push_expect(1'b1, 1'b0, 1'b0); send_frame(-1, -1, 1, 1'b0);
        build_good(); frm[10] = 8'hFF; push_expect(1'b0, 1'b0, 1'b0); send_frame(-1, -1, 1, 1'b0);
        build_good(); push_expect(1'b0, 1'b1, 1'b0); send_frame(6, -1, 1, 1'b0);
        build_good(); push_expect(1'b0, 1'b0, 1'b1); send_frame(-1, 61, 1, 1'b0);

        // Bad preamble nibble: whole frame dropped, next good frame accepted
        build_good(); send_frame(-1, -1, 1, 1'b1);
        build_good(); push_expect(1'b1, 1'b0, 1'b0); send_frame(-1, -1, 2, 1'b0);

        // SFD followed directly by dv=0
        frm.delete(); push_expect(1'b0, 1'b0, 1'b0); send_frame(-1, -1, 2, 1'b0);

        // Reset at byte 20 with dv held high; the tail carries a fake preamble+SFD
        build_good();
        frm[22] = 8'h55;
        frm[23] = 8'hD5;
`ifdef RX_FCS_STRIP_EN
        n_keep = 14;
`else
        n_keep = 18;
`endif
        cur_id++;
        for (int i = 0; i < n_keep; i++)
            exp_b.push_back('{b: frm[i], sof: (i == 0), id: 8'(cur_id)});
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 4'h5);
        drive(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, frm[i][3:0]);
            drive(1'b1, 1'b0, frm[i][7:4]);
        end
        @(posedge sys_clk);
        #1;
        sys_rst   = 1'b1;
        mii_rx_dv = 1'b1;
        mii_rxd   = frm[20][3:0];
        #1;
        chk("rst_strobes_clear", 64'({rx_byte_vld, rx_sof, rx_done, rx_crc_ok, rx_err_align, rx_err_phy}), 64'h0);
        chk("rst_data_clear", 64'({rx_byte, rx_len}), 64'h0);
        drive(1'b1, 1'b0, frm[20][7:4]);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        mii_rxd = frm[21][3:0];
        drive(1'b1, 1'b0, frm[21][7:4]);
        for (int i = 22; i < frm.size(); i++) begin
            drive(1'b1, 1'b0, frm[i][3:0]);
            drive(1'b1, 1'b0, frm[i][7:4]);
        end
        repeat (2) drive(1'b0, 1'b0, 4'h0);

        build_good(); push_expect(1'b1, 1'b0, 1'b0); send_frame(-1, -1, 4, 1'b0);

        repeat (20) @(posedge sys_clk);
        chk("bytes_outstanding", 64'(exp_b.size()), 64'h0);
        chk("done_outstanding", 64'(exp_d.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_mii_rx_fcs.md
# eth_mii_rx_fcs

Receive-side counterpart of the nibble-wide CRC-32 transmit path. Samples the MII receive nibble stream, finds preamble/SFD, assembles bytes LSB-nibble first, and runs CRC-32 over the whole frame including FCS. At end of frame it checks the CRC residue and reports status. It sits between the PHY's MII RX pins (synchronous to rx_clk, used as sys_clk) and the UDP/IP receive parser.

## Interface
- LEN_W, 11: width of rx_len; saturates at 2^LEN_W-1.
- sys_clk  in  1  MII receive clock, one nibble per cycle. Reset is asynchronous and active-high.
- sys_rst  in  1  Asynchronous, active-high reset.
- mii_rx_dv  in  1  MII data valid.
- mii_rx_er  in  1  MII receive error.
- mii_rxd  in  4  MII nibble; bit0 is first on the wire.
- rx_byte  out  8  Frame byte after SFD; {high nibble, low nibble}.
- rx_byte_vld  out  1  One-cycle strobe per byte.
- rx_sof  out  1  Coincides with rx_byte_vld of the first byte of a frame.
- rx_done  out  1  One-cycle end-of-frame strobe; the status outputs below are valid while it is high.
- rx_crc_ok  out  1  CRC residue matched, nibble count even, and byte count ≥ 4.
- rx_err_align  out  1  Odd number of nibbles after SFD.
- rx_err_phy  out  1  mii_rx_er seen during DATA.
- rx_len  out  LEN_W  Bytes delivered on rx_byte for this frame.

## Operation
- The inputs mii_rx_dv, mii_rx_er and mii_rxd are registered once (in-reg). All logic uses the registered copies.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: dv=1 and nibble 0x5 → PREAMBLE. dv=1 and any other nibble → DROP.
  - PREAMBLE: nibble 0x5 → stay. Nibble 0xD → DATA, with CRC cleared to the init value and the nibble phase set to low. Any other nibble → DROP. dv=0 → IDLE with no rx_done.
  - DATA: each nibble is fed to the CRC and the phase toggles. On the high-nibble phase a byte is formed. dv=0 → IDLE and rx_done fires.
  - DROP: stay until dv=0, then → IDLE. No outputs are produced.
- CRC register form:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB-first shift.
  - Each nibble is bit-reversed before entry.
  - No final inversion.
  - Good frame residue is 0xC704DD7B.
- Status at rx_done:
  - rx_crc_ok = (crc == residue) && even nibble count && bytes ≥ 4 && !rx_err_phy.
  - A trailing odd nibble is discarded and sets rx_err_align.
- The byte counter saturates at 2^LEN_W-1. rx_len reports the saturated value.
- Reset mid-frame:
  - All outputs are cleared and the FSM goes to IDLE.
  - No rx_done is produced for the interrupted frame.
  - If dv is still high when reset releases, the remaining frame goes to DROP. The 0x5 stream restarts the FSM only after dv=0.
- Entering DATA and then dv=0 with zero bytes: rx_done fires with rx_len=0, rx_crc_ok=0.
- Back-to-back frames need only one dv=0 cycle between them. rx_done of frame A may coincide with PREAMBLE of frame B.

## Timing
- Reset values of all outputs are 0.
- rx_byte_vld/rx_byte are registered. They assert 2 cycles after the sys_clk edge that samples the high nibble on mii_rxd, plus 8 cycles when stripping is enabled.
- The byte strobe occurs at most once per 2 cycles.
- rx_done asserts 2 cycles after the edge that first samples mii_rx_dv=0. It is always after the last rx_byte_vld.

## Configuration
- RX_FCS_STRIP_EN defined:
  - A 4-byte delay line withholds bytes. A byte is emitted only when a 5th byte arrives, so the 4 FCS bytes are never output.
  - rx_len = total bytes − 4, floored at 0.
- RX_FCS_STRIP_EN undefined:
  - Every byte, including FCS, is emitted with no delay line.
  - rx_len = total bytes.

## Structure
- Package eth_rx_pkg holds:
  - The FSM state enum.
  - CRC32_POLY, CRC32_INIT=32'hFFFFFFFF and CRC32_RESIDUE=32'hC704DD7B.
  - PREAMBLE_NIB=4'h5 and SFD_NIB=4'hD.
- One sub-module, eth_crc32_nib: registered nibble CRC update with en/clr inputs and active-high async reset.
- FSM, nibble assembly, delay line and status all live in the top.

## Test plan
- Good frame: 15×0x5, 0xD, 60-byte payload 0x00..0x3B, then its correct FCS. With strip: 60 byte strobes, rx_sof on byte 0x00, rx_done with rx_crc_ok=1, rx_len=60. Without strip: rx_len=64.
- Same frame with payload byte 10 flipped to 0xFF: all bytes are still delivered; rx_done with rx_crc_ok=0 and both error flags 0.
- Good frame plus one extra nibble before dv drops: rx_err_align=1, rx_crc_ok=0.
- mii_rx_er pulsed for one cycle mid-payload: rx_err_phy=1, rx_crc_ok=0, rx_len unchanged.
- Preamble nibble 0xA instead of 0x5: no rx_byte_vld and no rx_done until dv falls. A following good frame after 1 idle cycle passes with rx_crc_ok=1.
- sys_rst asserted at byte 20 with dv still high: outputs go to 0 immediately. No rx_done, no bytes for the rest of that frame. The next good frame passes.
